// File: rtl/text_line_reader_pkg.sv
// Shared text RAM / console definitions for the text read path.
package text_line_reader_pkg;

    localparam int unsigned TEXT_RAM_CHAR_WIDTH = 32;
    localparam int unsigned CONSOLE_COLUMNS     = 16;
    localparam int unsigned CONSOLE_LINES       = 30;
    localparam int unsigned TEXT_RAM_LINE_WIDTH = TEXT_RAM_CHAR_WIDTH * CONSOLE_COLUMNS;
    localparam logic [31:0] EMPTY_DATA          = 32'h0007fc20;

    typedef struct packed {
        logic                           write;
        logic [7:0]                     address;
        logic [TEXT_RAM_LINE_WIDTH-1:0] data;
    } TextRamRequest_t;

    typedef struct packed {
        logic [TEXT_RAM_LINE_WIDTH-1:0] data;
    } TextRamResult_t;

    typedef struct packed {
        logic [7:0] address;
    } TextRamReadRequest_t;

    localparam logic [1:0] F_IDLE  = 2'd0;
    localparam logic [1:0] F_WAIT  = 2'd1;
    localparam logic [1:0] F_LATCH = 2'd2;
    localparam logic [1:0] F_BLANK = 2'd3;

endpackage

// File: rtl/text_line_reader_buffer.sv
// One line buffer: whole-line write (RAM data or blank fill), per-column read.
module text_line_buffer
    import text_line_reader_pkg::*;
#(
    parameter int unsigned COLUMNS = CONSOLE_COLUMNS,
    parameter int unsigned CHAR_W  = TEXT_RAM_CHAR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic                      wr_blank,
    input  logic [CHAR_W*COLUMNS-1:0] wr_line,
    input  logic [7:0]                wr_row,
    input  logic [7:0]                wr_cursor_row,
    input  logic [7:0]                wr_cursor_col,
    input  logic                      wr_cursor_en,
    input  logic                      clr,
    input  logic [7:0]                rd_col,
    output logic                      full,
    output logic [CHAR_W-1:0]         rd_cell,
    output logic [7:0]                row,
    output logic                      rd_cursor
);

    localparam logic [CHAR_W-1:0] BLANK_CELL = CHAR_W'(EMPTY_DATA);

    logic [CHAR_W*COLUMNS-1:0] line;
    logic [7:0]                cursor_row;
    logic [7:0]                cursor_col;
    logic                      cursor_en;

    // A clear and a set in the same cycle leave the buffer full (clear first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full       <= 1'b0;
            line       <= '0;
            row        <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            cursor_en  <= 1'b0;
        end else begin
            if (clr)
                full <= 1'b0;
            if (wr_en) begin
                full       <= 1'b1;
                line       <= wr_blank ? {COLUMNS{BLANK_CELL}} : wr_line;
                row        <= wr_row;
                cursor_row <= wr_cursor_row;
                cursor_col <= wr_cursor_col;
                cursor_en  <= wr_cursor_en;
            end
        end
    end

    always_comb begin
        rd_cell = '0;
        for (int unsigned c = 0; c < COLUMNS; c++)
            if (rd_col == 8'(c))
                rd_cell = line[c*CHAR_W +: CHAR_W];
    end

    assign rd_cursor = cursor_en && (cursor_row == row) && (cursor_col == rd_col);

endmodule

// File: rtl/text_line_reader.sv
// Fetches a text row into one of two line buffers and streams it cell by cell.
module text_line_reader
    import text_line_reader_pkg::*;
#(
    parameter int unsigned COLUMNS    = CONSOLE_COLUMNS,
    parameter int unsigned LINES      = CONSOLE_LINES,
    parameter int unsigned CHAR_W     = TEXT_RAM_CHAR_WIDTH,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic [7:0]                req_row,
    output logic                      req_ready,
    output logic [7:0]                rd_address,
    input  logic [CHAR_W*COLUMNS-1:0] rd_data,
    input  logic [7:0]                cursor_row,
    input  logic [7:0]                cursor_col,
    input  logic                      cursor_en,
    output logic                      char_valid,
    input  logic                      char_ready,
    output logic [CHAR_W-1:0]         char_data,
    output logic [7:0]                char_col,
    output logic [7:0]                char_row,
    output logic                      char_last,
    output logic                      char_cursor
);

    localparam int unsigned CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic                fill_ptr;
    logic                drain_ptr;
    logic [7:0]          col;
    logic [7:0]          lat_row;
    logic [7:0]          lat_cursor_row;
    logic [7:0]          lat_cursor_col;
    logic                lat_cursor_en;
    TextRamReadRequest_t rd_req;

    logic                accept;
    logic                fill_done;
    logic                last_beat;
    logic [1:0]          full;
    logic [CHAR_W-1:0]   cell0, cell1;
    logic [7:0]          row0, row1;
    logic                cur0, cur1;

    assign req_ready  = (state == F_IDLE) && !full[fill_ptr];
    assign accept     = req_valid && req_ready;
    assign fill_done  = (state == F_LATCH) || (state == F_BLANK);
    assign last_beat  = char_valid && char_ready && char_last;
    assign rd_address = rd_req.address;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= F_IDLE;
            cnt            <= '0;
            fill_ptr       <= 1'b0;
            lat_row        <= '0;
            lat_cursor_row <= '0;
            lat_cursor_col <= '0;
            lat_cursor_en  <= 1'b0;
            rd_req         <= '0;
        end else begin
            case (state)
                F_IDLE: if (accept) begin
                    lat_row        <= req_row;
                    lat_cursor_row <= cursor_row;
                    lat_cursor_col <= cursor_col;
                    lat_cursor_en  <= cursor_en;
                    if (32'(req_row) < LINES) begin
                        rd_req.address <= req_row;
                        cnt            <= CNT_W'(RD_LATENCY - 1);
                        state          <= F_WAIT;
                    end else begin
                        state <= F_BLANK;
                    end
                end
                F_WAIT: begin
                    if (cnt == '0)
                        state <= F_LATCH;
                    else
                        cnt <= cnt - 1'b1;
                end
                F_LATCH, F_BLANK: begin
                    fill_ptr <= ~fill_ptr;
                    state    <= F_IDLE;
                end
                default: state <= F_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            drain_ptr <= 1'b0;
        end else if (char_valid && char_ready) begin
            if (char_last) begin
                col       <= '0;
                drain_ptr <= ~drain_ptr;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

    text_line_buffer #(.COLUMNS(COLUMNS), .CHAR_W(CHAR_W)) u_buf0 (
        .clk(clk), .rst(rst),
        .wr_en(fill_done && !fill_ptr), .wr_blank(state == F_BLANK), .wr_line(rd_data),
        .wr_row(lat_row), .wr_cursor_row(lat_cursor_row), .wr_cursor_col(lat_cursor_col),
        .wr_cursor_en(lat_cursor_en), .clr(last_beat && !drain_ptr), .rd_col(col),
        .full(full[0]), .rd_cell(cell0), .row(row0), .rd_cursor(cur0)
    );

    text_line_buffer #(.COLUMNS(COLUMNS), .CHAR_W(CHAR_W)) u_buf1 (
        .clk(clk), .rst(rst),
        .wr_en(fill_done && fill_ptr), .wr_blank(state == F_BLANK), .wr_line(rd_data),
        .wr_row(lat_row), .wr_cursor_row(lat_cursor_row), .wr_cursor_col(lat_cursor_col),
        .wr_cursor_en(lat_cursor_en), .clr(last_beat && drain_ptr), .rd_col(col),
        .full(full[1]), .rd_cell(cell1), .row(row1), .rd_cursor(cur1)
    );

    assign char_valid  = full[drain_ptr];
    assign char_data   = drain_ptr ? cell1 : cell0;
    assign char_row    = drain_ptr ? row1 : row0;
    assign char_cursor = drain_ptr ? cur1 : cur0;
    assign char_col    = col;
    assign char_last   = (col == 8'(COLUMNS - 1));

endmodule

// File: tb/tb_text_line_reader.sv
// Directed bench for text_line_reader with a latency-accurate text RAM model.
module tb_text_line_reader;
    import text_line_reader_pkg::*;

    localparam int unsigned COLS = CONSOLE_COLUMNS;
    localparam int unsigned LNS  = CONSOLE_LINES;
    localparam int unsigned CW   = TEXT_RAM_CHAR_WIDTH;
    localparam int unsigned LAT  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic [7:0]        req_row;
    logic              req_ready;
    logic [7:0]        rd_address;
    logic [CW*COLS-1:0] rd_data;
    logic [7:0]        cursor_row, cursor_col;
    logic              cursor_en;
    logic              char_valid, char_ready;
    logic [CW-1:0]     char_data;
    logic [7:0]        char_col, char_row;
    logic              char_last, char_cursor;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    text_line_reader #(.COLUMNS(COLS), .LINES(LNS), .CHAR_W(CW), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_row(req_row), .req_ready(req_ready),
        .rd_address(rd_address), .rd_data(rd_data), .cursor_row(cursor_row),
        .cursor_col(cursor_col), .cursor_en(cursor_en), .char_valid(char_valid),
        .char_ready(char_ready), .char_data(char_data), .char_col(char_col),
        .char_row(char_row), .char_last(char_last), .char_cursor(char_cursor)
    );

    // RAM contents; rows beyond LINES hold garbage so blanking is visible.
    function automatic logic [CW-1:0] ram_cell(input logic [7:0] row, input int unsigned col);
        logic [7:0] code;
        if (32'(row) >= LNS) return 32'hdeadbe00 | 32'(col);
        if (row == 8'd5 && col == 0) code = 8'h41;
        else if (row == 8'd5 && col == COLS - 1) code = 8'h42;
        else code = 8'(8'h60 + col);
        return {8'h07, row, 8'(col), code};
    endfunction

    function automatic logic [CW-1:0] exp_cell(input logic [7:0] row, input int unsigned col);
        if (32'(row) >= LNS) return EMPTY_DATA;
        return ram_cell(row, col);
    endfunction

    function automatic logic [CW*COLS-1:0] ram_line(input logic [7:0] row);
        logic [CW*COLS-1:0] l;
        for (int unsigned c = 0; c < COLS; c++) l[c*CW +: CW] = ram_cell(row, c);
        return l;
    endfunction

    logic [CW*COLS-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= ram_line(rd_address);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[LAT-1];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after accept.
    task automatic do_req(input logic [7:0] row, input logic [7:0] crow,
                          input logic [7:0] ccol, input logic cen);
        int n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) check("req_ready_timeout", req_ready, 1);
        req_valid = 1'b1; req_row = row;
        cursor_row = crow; cursor_col = ccol; cursor_en = cen;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain_line(input logic [7:0] row, input int cur_col);
        int n = 0;
        char_ready = 1'b1;
        while (!char_valid && n < 100) begin @(negedge clk); n++; end
        check($sformatf("drain_wait r%0d", row), char_valid, 1);
        for (int c = 0; c < int'(COLS); c++) begin
            check($sformatf("beat_valid r%0d c%0d", row, c), char_valid, 1);
            check($sformatf("beat_data r%0d c%0d", row, c), char_data, exp_cell(row, c));
            check($sformatf("beat_col r%0d c%0d", row, c), char_col, c);
            check($sformatf("beat_row r%0d c%0d", row, c), char_row, row);
            check($sformatf("beat_last r%0d c%0d", row, c), char_last, c == int'(COLS) - 1);
            check($sformatf("beat_cursor r%0d c%0d", row, c), char_cursor, c == cur_col);
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] row;
        logic [7:0] crow;
        logic [7:0] ccol;
        logic       cen;
        int         exp_cur;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] d, p_data;
        logic [7:0]    p_col, p_row;
        logic          p_last, stalled;
        int unsigned   exp_col;
        int            n;

        vecs[0] = '{8'd7,  8'd7,  8'd10, 1'b1, 10};
        vecs[1] = '{8'd7,  8'd7,  8'd10, 1'b0, -1};
        vecs[2] = '{8'd8,  8'd7,  8'd10, 1'b1, -1};
        vecs[3] = '{8'd0,  8'd0,  8'd0,  1'b1, 0};
        vecs[4] = '{8'd29, 8'd29, 8'd15, 1'b1, 15};
        vecs[5] = '{8'd30, 8'd30, 8'd3,  1'b1, 3};

        rst = 1'b1; req_valid = 1'b0; req_row = '0; char_ready = 1'b0;
        cursor_row = '0; cursor_col = '0; cursor_en = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_char_valid", char_valid, 0);
        check("rst_rd_address", rd_address, 0);
        check("rst_char_data", char_data, 0);
        check("rst_char_col", char_col, 0);
        check("rst_char_row", char_row, 0);
        check("rst_char_last", char_last, 0);
        check("rst_char_cursor", char_cursor, 0);
        rst = 1'b0;
        @(negedge clk);

        // Fetch latency: valid appears in cycle 4 after accept.
        char_ready = 1'b1;
        do_req(8'd5, 8'd0, 8'd0, 1'b0);
        check("lat_rd_address_c1", rd_address, 5);
        check("lat_valid_c1", char_valid, 0);
        @(negedge clk); check("lat_valid_c2", char_valid, 0);
        @(negedge clk); check("lat_valid_c3", char_valid, 0);
        @(negedge clk); check("lat_valid_c4", char_valid, 1);
        d = char_data;
        check("row5_first_code", d[7:0], 8'h41);
        drain_line(8'd5, -1);

        // Out-of-range row: blank fill, RAM address untouched.
        do_req(8'd200, 8'd0, 8'd0, 1'b0);
        check("blank_rd_address", rd_address, 5);
        check("blank_valid_c1", char_valid, 0);
        @(negedge clk); check("blank_valid_c2", char_valid, 1);
        drain_line(8'd200, -1);
        check("blank_rd_address_after", rd_address, 5);

        for (int i = 0; i < 6; i++) begin
            do_req(vecs[i].row, vecs[i].crow, vecs[i].ccol, vecs[i].cen);
            drain_line(vecs[i].row, vecs[i].exp_cur);
        end

        // Both buffers full: row 3 waits for row 1's last beat.
        char_ready = 1'b0;
        do_req(8'd1, 8'd0, 8'd0, 1'b0);
        do_req(8'd2, 8'd0, 8'd0, 1'b0);
        req_valid = 1'b1; req_row = 8'd3;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b2b_ready_held", req_ready, 0);
            check("b2b_stall_row", char_row, 1);
            check("b2b_stall_col", char_col, 0);
            check("b2b_stall_valid", char_valid, 1);
        end
        char_ready = 1'b1;
        for (int c = 0; c < int'(COLS); c++) begin
            check("b2b_row1_row", char_row, 1);
            check("b2b_row1_col", char_col, c);
            if (c == int'(COLS) - 1) check("b2b_ready_on_last", req_ready, 0);
            @(negedge clk);
        end
        check("b2b_ready_after_last", req_ready, 1);
        check("b2b_row2_next", char_row, 2);
        check("b2b_row2_col0", char_col, 0);
        char_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        drain_line(8'd2, -1);
        drain_line(8'd3, -1);

        // Random backpressure on row 4.
        char_ready = 1'b0;
        do_req(8'd4, 8'd0, 8'd0, 1'b0);
        exp_col = 0; stalled = 1'b0; n = 0;
        p_data = '0; p_col = '0; p_row = '0; p_last = 1'b0;
        while (exp_col < COLS && n < 400) begin
            if (stalled) begin
                check("rand_stable_data", char_data, p_data);
                check("rand_stable_col", char_col, p_col);
                check("rand_stable_row", char_row, p_row);
                check("rand_stable_last", char_last, p_last);
            end
            if (char_valid) begin
                check($sformatf("rand_col %0d", exp_col), char_col, exp_col);
                check($sformatf("rand_data %0d", exp_col), char_data, exp_cell(8'd4, exp_col));
                check("rand_row", char_row, 4);
            end
            char_ready = 1'($urandom_range(0, 1));
            stalled = char_valid && !char_ready;
            p_data = char_data; p_col = char_col; p_row = char_row; p_last = char_last;
            if (char_valid && char_ready) exp_col++;
            @(negedge clk);
            n++;
        end
        check("rand_all_delivered", exp_col, COLS);
        check("rand_no_extra", char_valid, 0);

        // Reset in cycle 2 of a fetch.
        char_ready = 1'b1;
        do_req(8'd9, 8'd0, 8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstfetch_valid", char_valid, 0);
        check("rstfetch_ready", req_ready, 1);
        check("rstfetch_rd_address", rd_address, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rstfetch_no_stale", char_valid, 0);
        end
        do_req(8'd9, 8'd0, 8'd0, 1'b0);
        drain_line(8'd9, -1);

        // Reset mid-drain discards the partial line.
        do_req(8'd6, 8'd0, 8'd0, 1'b0);
        n = 0;
        while (!char_valid && n < 20) begin @(negedge clk); n++; end
        @(negedge clk); @(negedge clk);
        char_ready = 1'b0;
        check("rstdrain_mid_col", char_col, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstdrain_valid", char_valid, 0);
        check("rstdrain_col", char_col, 0);
        check("rstdrain_ready", req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
